// File: rtl/note_key_scanner.sv
// Piano key front end: synchronizes and debounces 8 raw keys, then encodes the
// committed key vector into a 4-bit note code with a change strobe and chord flag.
module note_key_scanner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] KEYS,
  output logic [3:0] NOTE,
  output logic       NOTE_STROBE,
  output logic       CHORD
);

  localparam int unsigned KEY_W  = 8;
  localparam int unsigned NOTE_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state;
  logic [KEY_W-1:0]   sync_meta;
  logic [KEY_W-1:0]   key_sync;
  logic [KEY_W-1:0]   key_cand;
  logic [CNT_W-1:0]   cnt;
  logic [NOTE_W-1:0]  enc_note_c;
  logic               enc_chord_c;
  logic [NOTE_W-1:0]  ones_c;

  // Two-flop synchronizer; KEYS is asynchronous to CLK.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_meta <= '0;
      key_sync  <= '0;
    end else begin
      sync_meta <= KEYS;
      key_sync  <= sync_meta;
    end
  end

  // Encode the candidate vector; chords never yield a note.
  always_comb begin
    enc_note_c  = '0;
    enc_chord_c = 1'b0;
    ones_c      = NOTE_W'($countones(key_cand));
    if (ones_c >= NOTE_W'(2)) begin
      enc_chord_c = 1'b1;
    end else if (ones_c == NOTE_W'(1)) begin
      for (int i = 0; i < int'(KEY_W); i++) begin
        if (key_cand[i]) enc_note_c = NOTE_W'(i + 1);
      end
    end
  end

  // Debounce FSM; NOTE/CHORD hold the committed vector's encoding.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      key_cand    <= '0;
      cnt         <= '0;
      NOTE        <= '0;
      NOTE_STROBE <= 1'b0;
      CHORD       <= 1'b0;
    end else begin
      NOTE_STROBE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (key_sync != key_cand) begin
            key_cand <= key_sync;
            cnt      <= '0;
            state    <= COUNT;
          end
        end
        COUNT: begin
          if (key_sync != key_cand) begin
            key_cand <= key_sync;
            cnt      <= '0;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          NOTE        <= enc_note_c;
          CHORD       <= enc_chord_c;
          NOTE_STROBE <= (enc_note_c != NOTE);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_key_scanner.sv
// Directed bench for note_key_scanner with DEBOUNCE_CYCLES=4: commit lands on the
// 8th rising edge (edge 7) after KEYS settles.
module tb_note_key_scanner;

  logic       CLK;
  logic       RESET;
  logic [7:0] KEYS;
  logic [3:0] NOTE;
  logic       NOTE_STROBE;
  logic       CHORD;

  int checks   = 0;
  int failures = 0;
  logic [3:0] cur_note;

  typedef struct {
    logic [7:0] keys;
    logic [3:0] note;
    logic       chord;
    logic       strobe;
  } vec_t;

  vec_t vecs [10];

  note_key_scanner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .KEYS        (KEYS),
    .NOTE        (NOTE),
    .NOTE_STROBE (NOTE_STROBE),
    .CHORD       (CHORD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // KEYS must already be settled before the next edge (edge 0).
  task automatic wait_commit(input logic [3:0] note, input logic chord, input logic strobe);
    for (int e = 0; e < 7; e++) begin
      tick();
      check("hold_note", 8'(NOTE), 8'(cur_note));
      check("hold_strobe", 8'(NOTE_STROBE), 8'd0);
    end
    tick();
    check("commit_note", 8'(NOTE), 8'(note));
    check("commit_chord", 8'(CHORD), 8'(chord));
    check("commit_strobe", 8'(NOTE_STROBE), 8'(strobe));
    tick();
    check("strobe_clear", 8'(NOTE_STROBE), 8'd0);
    check("note_kept", 8'(NOTE), 8'(note));
    cur_note = note;
  endtask

  task automatic apply(input logic [7:0] keys, input logic [3:0] note,
                       input logic chord, input logic strobe);
    tick();
    KEYS = keys;
    wait_commit(note, chord, strobe);
  endtask

  initial begin
    vecs[0] = '{keys: 8'h01, note: 4'd1, chord: 1'b0, strobe: 1'b1};
    vecs[1] = '{keys: 8'h00, note: 4'd0, chord: 1'b0, strobe: 1'b1};
    vecs[2] = '{keys: 8'h05, note: 4'd0, chord: 1'b1, strobe: 1'b0};
    vecs[3] = '{keys: 8'h04, note: 4'd3, chord: 1'b0, strobe: 1'b1};
    vecs[4] = '{keys: 8'h0C, note: 4'd0, chord: 1'b1, strobe: 1'b1};
    vecs[5] = '{keys: 8'h00, note: 4'd0, chord: 1'b0, strobe: 1'b0};
    vecs[6] = '{keys: 8'h80, note: 4'd8, chord: 1'b0, strobe: 1'b1};
    vecs[7] = '{keys: 8'h40, note: 4'd7, chord: 1'b0, strobe: 1'b1};
    vecs[8] = '{keys: 8'hFF, note: 4'd0, chord: 1'b1, strobe: 1'b1};
    vecs[9] = '{keys: 8'h00, note: 4'd0, chord: 1'b0, strobe: 1'b0};

    // Reset with a key held, then full latency after release.
    RESET = 1'b0;
    KEYS  = 8'h04;
    cur_note = 4'd0;
    repeat (3) tick();
    check("rst_note", 8'(NOTE), 8'd0);
    check("rst_chord", 8'(CHORD), 8'd0);
    check("rst_strobe", 8'(NOTE_STROBE), 8'd0);
    RESET = 1'b1;
    wait_commit(4'd3, 1'b0, 1'b1);

    foreach (vecs[i]) apply(vecs[i].keys, vecs[i].note, vecs[i].chord, vecs[i].strobe);

    // Short dropout on a held key: same vector recommitted, never a strobe.
    apply(8'h10, 4'd5, 1'b0, 1'b1);
    tick();
    KEYS = 8'h00;
    repeat (2) tick();
    KEYS = 8'h10;
    for (int c = 0; c < 16; c++) begin
      tick();
      check("glitch_note", 8'(NOTE), 8'd5);
      check("glitch_strobe", 8'(NOTE_STROBE), 8'd0);
    end

    // Bounce on bit7 every 3 cycles, then settle high.
    apply(8'h00, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      KEYS = (i % 2 == 0) ? 8'h80 : 8'h00;
      for (int c = 0; c < 3; c++) begin
        tick();
        check("bounce_note", 8'(NOTE), 8'd0);
        check("bounce_strobe", 8'(NOTE_STROBE), 8'd0);
      end
    end
    KEYS = 8'h80;
    wait_commit(4'd8, 1'b0, 1'b1);

    // Reset while counting clears outputs immediately; then full re-debounce.
    tick();
    KEYS = 8'h02;
    repeat (4) tick();
    RESET = 1'b0;
    #1;
    check("midrst_note", 8'(NOTE), 8'd0);
    check("midrst_chord", 8'(CHORD), 8'd0);
    check("midrst_strobe", 8'(NOTE_STROBE), 8'd0);
    repeat (2) tick();
    RESET = 1'b1;
    cur_note = 4'd0;
    wait_commit(4'd2, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
